// File: rtl/bus_rr_scheduler_if.sv
// Bus-side bundle between the device FIFOs / receive ports and the round-robin scheduler.
interface bus_rr_scheduler_if #(
  parameter int unsigned drvrs  = 4,
  parameter int unsigned pkg_sz = 24,
  parameter int unsigned cnt_w  = 16
);
  localparam int unsigned id_w = $clog2(drvrs);

  logic [drvrs-1:0]        pndng;
  logic [drvrs*pkg_sz-1:0] D_pop;
  logic [drvrs-1:0]        pop;
  logic [drvrs-1:0]        push;
  logic [pkg_sz-1:0]       D_push;
  logic [id_w-1:0]         grant_id;
  logic                    busy;
  logic [cnt_w-1:0]        drop_cnt;
  logic [cnt_w-1:0]        pkt_cnt;

  // Scheduler side
  modport master (
    input  pndng, D_pop,
    output pop, push, D_push, grant_id, busy, drop_cnt, pkt_cnt
  );

  // Device side
  modport slave (
    output pndng, D_pop,
    input  pop, push, D_push, grant_id, busy, drop_cnt, pkt_cnt
  );
endinterface

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler/router: pops one packet from a pending source FIFO and
// pushes it to its destination (or all other devices on broadcast).
module bus_rr_scheduler #(
  parameter int unsigned drvrs     = 4,
  parameter int unsigned pkg_sz    = 24,
  parameter logic [7:0]  broadcast = 8'hFF,
  parameter int unsigned cnt_w     = 16
) (
  input logic             clk,
  input logic             reset,
  bus_rr_scheduler_if.master bus
);
  localparam int unsigned id_w = $clog2(drvrs);

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_pop  = 2'd1;
  localparam logic [1:0] st_push = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [id_w-1:0]   grant_q, grant_d;
  logic [drvrs-1:0]  pop_q, pop_d;
  logic [drvrs-1:0]  push_q, push_d;
  logic [pkg_sz-1:0] pkt_q, pkt_d;
  logic              busy_q;
  logic [cnt_w-1:0]  drop_q, drop_d;
  logic [cnt_w-1:0]  pkt_cnt_q, pkt_cnt_d;

  logic [id_w-1:0]   winner_c;
  logic [pkg_sz-1:0] head_c;
  logic [7:0]        dest_c;
  logic [drvrs-1:0]  mask_c;
  logic              drop_c;

  // Round-robin search starting one past the last grant; lowest offset wins
  always_comb begin
    winner_c = grant_q;
    for (int k = int'(drvrs); k >= 1; k--) begin
      logic [id_w-1:0] idx;
      idx = id_w'((32'(grant_q) + 32'(k)) % drvrs);
      if (bus.pndng[idx]) winner_c = idx;
    end
  end

  // Destination decode of the granted FIFO head word
  always_comb begin
    head_c = bus.D_pop[32'(grant_q) * pkg_sz +: pkg_sz];
    dest_c = head_c[pkg_sz-1 -: 8];
    mask_c = '0;
    drop_c = 1'b1;
    if (dest_c == broadcast) begin
      mask_c = ~(drvrs'(1) << grant_q);
      drop_c = 1'b0;
    end else if ((32'(dest_c) < drvrs) && (32'(dest_c) != 32'(grant_q))) begin
      mask_c = drvrs'(1) << dest_c;
      drop_c = 1'b0;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    pop_d     = '0;
    push_d    = '0;
    pkt_d     = pkt_q;
    drop_d    = drop_q;
    pkt_cnt_d = pkt_cnt_q;
    case (state_q)
      st_idle: begin
        if (|bus.pndng) begin
          grant_d = winner_c;
          pop_d   = drvrs'(1) << winner_c;
          state_d = st_pop;
        end
      end
      st_pop: begin
        if (drop_c) begin
          if (drop_q != '1) drop_d = drop_q + cnt_w'(1);
          state_d = st_idle;
        end else begin
          push_d  = mask_c;
          pkt_d   = head_c;
          state_d = st_push;
        end
      end
      st_push: begin
        if (pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + cnt_w'(1);
        state_d = st_idle;
      end
      default: state_d = st_idle;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= st_idle;
      grant_q   <= id_w'(drvrs - 1);
      pop_q     <= '0;
      push_q    <= '0;
      pkt_q     <= '0;
      busy_q    <= 1'b0;
      drop_q    <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pop_q     <= pop_d;
      push_q    <= push_d;
      pkt_q     <= pkt_d;
      busy_q    <= (state_d != st_idle);
      drop_q    <= drop_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign bus.pop      = pop_q;
  assign bus.push     = push_q;
  assign bus.D_push   = pkt_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;
  assign bus.drop_cnt = drop_q;
  assign bus.pkt_cnt  = pkt_cnt_q;
endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Scoreboard bench for bus_rr_scheduler: directed steps push expected transfers,
// a negedge monitor pops and compares them against pop/push activity.
module tb_bus_rr_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    int          src;
    logic [3:0]  mask;
    logic [23:0] data;
    bit          drop;
    int          pop_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   in_flight = 1'b0;

  bus_rr_scheduler_if #(.drvrs(4), .pkg_sz(24), .cnt_w(16)) bus ();

  bus_rr_scheduler #(.drvrs(4), .pkg_sz(24), .broadcast(8'hFF), .cnt_w(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent model of the routing decision for one packet
  function automatic exp_t model(input int src, input logic [23:0] d, input int pc);
    exp_t e;
    logic [7:0] dest;
    dest = d[23:16];
    e.src = src;
    e.data = d;
    e.pop_cyc = pc;
    e.drop = 1'b0;
    e.mask = 4'h0;
    if (dest == 8'hFF) begin
      for (int i = 0; i < 4; i++) e.mask[i] = (i != src);
    end else if (int'(dest) < 4 && int'(dest) != src) begin
      e.mask[dest[1:0]] = 1'b1;
    end else begin
      e.drop = 1'b1;
    end
    return e;
  endfunction

  // Single-source transfer: pndng high for one IDLE sample, then released
  task automatic send(input int src, input logic [23:0] d);
    bus.D_pop[src*24 +: 24] = d;
    sb.push_back(model(src, d, cyc + 1));
    bus.pndng[src] = 1'b1;
    @(posedge clk); #1;
    bus.pndng[src] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Monitor: every pop must match the scoreboard head; the next cycle carries its push
  always @(negedge clk) begin
    if (mon_en) begin
      if (in_flight) begin
        check("push_mask", 32'(bus.push), cur.drop ? 32'h0 : 32'(cur.mask));
        if (!cur.drop) check("d_push", 32'(bus.D_push), 32'(cur.data));
        check("pop_cleared", 32'(bus.pop), 32'h0);
        in_flight = 1'b0;
      end else if (bus.pop !== 4'h0) begin
        check("pop_expected", 32'(sb.size() != 0), 32'h1);
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          check("pop_onehot", 32'(bus.pop), 32'h1 << cur.src);
          check("grant_id", 32'(bus.grant_id), 32'(cur.src));
          check("pop_cycle", 32'(cyc), 32'(cur.pop_cyc));
          in_flight = 1'b1;
        end
      end else begin
        check("idle_push", 32'(bus.push), 32'h0);
      end
    end
  end

  initial begin
    bus.pndng = 4'h0;
    bus.D_pop = '0;

    // Reset held with all sources pending
    reset = 1'b0;
    bus.pndng = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pop", 32'(bus.pop), 32'h0);
    check("rst_push", 32'(bus.push), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_drop_cnt", 32'(bus.drop_cnt), 32'h0);
    check("rst_pkt_cnt", 32'(bus.pkt_cnt), 32'h0);
    check("rst_grant", 32'(bus.grant_id), 32'h3);
    check("rst_d_push", 32'(bus.D_push), 32'h0);
    bus.pndng = 4'h0;
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Unicast 1 -> 2
    send(1, 24'h02ABCD);
    check("uni_pkt_cnt", 32'(bus.pkt_cnt), 32'h1);
    check("uni_busy_after", 32'(bus.busy), 32'h0);

    // Broadcast from 2
    send(2, 24'hFF1234);
    check("bc_pkt_cnt", 32'(bus.pkt_cnt), 32'h2);
    check("bc_d_push_hold", 32'(bus.D_push), 32'hFF1234);

    // Nonexistent and self destination from source 0
    send(0, 24'h070001);
    send(0, 24'h000002);
    check("drop_cnt", 32'(bus.drop_cnt), 32'h2);
    check("drop_pkt_cnt", 32'(bus.pkt_cnt), 32'h2);
    check("drop_d_push_hold", 32'(bus.D_push), 32'hFF1234);

    // Reset asserted while a push is on the bus
    mon_en = 1'b0;
    bus.D_pop[1*24 +: 24] = 24'h035555;
    bus.pndng[1] = 1'b1;
    @(posedge clk); #1;
    bus.pndng[1] = 1'b0;
    check("mid_pop", 32'(bus.pop), 32'h2);
    @(posedge clk); #1;
    check("mid_push_before", 32'(bus.push), 32'h8);
    check("mid_busy_before", 32'(bus.busy), 32'h1);
    reset = 1'b0;
    #1;
    check("mid_push_async", 32'(bus.push), 32'h0);
    check("mid_busy_async", 32'(bus.busy), 32'h0);
    check("mid_grant", 32'(bus.grant_id), 32'h3);
    @(posedge clk); #1;
    check("mid_pkt_cnt", 32'(bus.pkt_cnt), 32'h0);
    check("mid_push_hold", 32'(bus.push), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Round-robin with all four sources continuously pending
    bus.D_pop[0*24 +: 24] = 24'h010A0A;
    bus.D_pop[1*24 +: 24] = 24'h021B1B;
    bus.D_pop[2*24 +: 24] = 24'hFF2C2C;
    bus.D_pop[3*24 +: 24] = 24'h003D3D;
    for (int k = 0; k < 5; k++) begin
      logic [23:0] d;
      d = bus.D_pop[(k % 4)*24 +: 24];
      sb.push_back(model(k % 4, d, cyc + 1 + 3*k));
    end
    bus.pndng = 4'hF;
    repeat (13) @(posedge clk);
    #1;
    bus.pndng = 4'h0;
    repeat (5) @(posedge clk);
    #1;
    check("rr_pkt_cnt", 32'(bus.pkt_cnt), 32'h5);
    check("rr_drop_cnt", 32'(bus.drop_cnt), 32'h0);
    check("rr_busy_end", 32'(bus.busy), 32'h0);
    check("sb_drained", 32'(sb.size()), 32'h0);
    check("no_open_transfer", 32'(in_flight), 32'h0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
